// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debouncer bank.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package debounce_pkg;

  // Per-channel state: settled on the current level, or timing a candidate change
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } ch_state_e;

  // Counter width able to hold 0 .. cycles-1; never narrower than one bit
  function automatic int cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Bundle of raw button inputs, repeat enables and debounced outputs.
// Latency: n/a (wires only).
// Backpressure: none; every output is a level or a single-cycle pulse.
interface debounce_bank_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] i_btn;
  logic [N_CH-1:0] i_rep_en;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_press;
  logic [N_CH-1:0] o_release;
  logic [N_CH-1:0] o_repeat;

  modport master (
    output i_btn, i_rep_en,
    input  o_level, o_press, o_release, o_repeat
  );

  modport slave (
    input  i_btn, i_rep_en,
    output o_level, o_press, o_release, o_repeat
  );
endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability FSM, press/release pulses, auto-repeat.
// Latency: level and press/release change SYNC_STAGES+STABLE_CYCLES cycles after btn settles.
// Backpressure: none; pulses are one cycle wide and are not held.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 65536,
  parameter int HOLD_CYCLES   = 1 << 24,
  parameter int REPEAT_CYCLES = 1 << 22
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_rep_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int CNT_W  = cnt_w(STABLE_CYCLES);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  // A repeat interval longer than the initial hold degenerates to the hold time
  localparam int RELOAD_I = (REPEAT_CYCLES >= HOLD_CYCLES) ? 0 : HOLD_CYCLES - REPEAT_CYCLES;

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RELOAD_I);

  logic [SYNC_STAGES-1:0] r_sync;
  ch_state_e              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [HOLD_W-1:0]      r_hold;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_repeat;

  logic w_s;
  logic w_accept;
  logic w_releasing;

  assign w_s         = r_sync[SYNC_STAGES-1];
  // The candidate level has now been seen for STABLE_CYCLES consecutive edges
  assign w_accept    = (r_state == ST_CHECK) && (w_s != r_level) && (r_cnt == CNT_LAST);
  assign w_releasing = w_accept && r_level;

  // Shift the raw button through the synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
  end

  // Stability FSM: time a candidate level, accept it with a press/release pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_STABLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (w_s != r_level) begin
            r_state <= ST_CHECK;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (w_s == r_level) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= ST_STABLE;
            r_cnt     <= '0;
            r_level   <= w_s;
            r_press   <= w_s;
            r_release <= ~w_s;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Hold counter: first repeat after HOLD_CYCLES, then every REPEAT_CYCLES; a release suppresses it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (!r_level || !i_rep_en || w_releasing) begin
        r_hold <= '0;
      end else if (r_hold == HOLD_LAST) begin
        r_repeat <= 1'b1;
        r_hold   <= HOLD_RELOAD;
      end else begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent button debouncers.
// Latency: SYNC_STAGES+STABLE_CYCLES cycles from a settled input to level/press/release.
// Backpressure: none; outputs are levels and one-cycle pulses.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 65536,
  parameter int HOLD_CYCLES   = 1 << 24,
  parameter int REPEAT_CYCLES = 1 << 22
) (
  input logic            clk,
  input logic            rst,
  debounce_bank_if.slave bus
);

  // One fully independent channel per button; nothing is shared between them
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_btn    (bus.i_btn[g]),
      .i_rep_en (bus.i_rep_en[g]),
      .o_level  (bus.o_level[g]),
      .o_press  (bus.o_press[g]),
      .o_release(bus.o_release[g]),
      .o_repeat (bus.o_repeat[g])
    );
  end

endmodule
